axis_pkt_gen: RTL and testbench
===============================

# axis_pkt_gen

AXI-Stream traffic generator: the transmit-side counterpart to our AXIS FIFOs and sinks. On a start pulse it emits a configured number of fixed-length packets with tlast framing and a deterministic, checkable payload. It honours downstream backpressure per AXI-Stream rules, with optional idle gaps between packets. It drives s_axis of buffering blocks in bring-up and regression benches, and serves as an on-chip BIST source.

## Interface
- WIDTH, 32, tdata width; even, ≥ 8
- LEN_WIDTH, 16, width of packet-length and beat counters
- GAP_WIDTH, 8, width of inter-packet gap counter
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches cfg_* and begins a run (IDLE only)
- stop  in  1  pulse; request graceful end of run
- cfg_len  in  LEN_WIDTH  beats per packet; 0 = start ignored
- cfg_num_pkts  in  16  packets per run; 0 = continuous until stop
- cfg_gap  in  GAP_WIDTH  idle cycles between packets
- cfg_mode  in  1  payload: 0 = incrementing, 1 = tagged
- m_axis_tdata  out  WIDTH  payload
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  downstream ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a run ends
- pkt_cnt  out  16  packets completed in current/last run

## Operation
- States: IDLE, SEND, GAP.
- IDLE: start && cfg_len != 0 → latch cfg into shadow registers, clear beat/word/pkt counters and stop_pending → SEND.
- SEND: tvalid = 1. Handshake = tvalid && tready; beat counter advances only on handshake. tlast = (beat == len−1).
- tlast handshake → pkt_cnt++. Then, in priority order:
  - stop_pending, or num_pkts ≠ 0 and new pkt_cnt == num_pkts → IDLE, done.
  - gap == 0 → stay in SEND, beat = 0.
  - otherwise → GAP with gap counter = gap.
- GAP: tvalid = 0; counter decrements each cycle; on reaching 1 → SEND. Stop in GAP → IDLE, done.
- stop in SEND sets stop_pending; the current packet always completes (never truncated). stop in IDLE: ignored. start while busy: ignored. start and stop in the same IDLE cycle: start wins, stop dropped.
- Payload mode 0: tdata = word counter (WIDTH bits, wraps modulo 2^WIDTH). Counter clears at start and increments on every handshake across packet boundaries.
- Payload mode 1: tdata[WIDTH−1:WIDTH/2] = pkt_cnt truncated; tdata[WIDTH/2−1:0] = beat index truncated.
- pkt_cnt wraps modulo 2^16 in continuous mode. It holds its value in IDLE until the next accepted start.

## Timing
- Reset: state IDLE; tvalid, tlast, tdata, busy, done, pkt_cnt all 0.
- start accepted at edge N → tvalid high from cycle N+1 (one-cycle latency); busy high from N+1.
- While tvalid && !tready: tdata, tlast and tvalid held stable; valid never drops without a handshake.
- Gap of G: exactly G cycles with tvalid low between the last-beat handshake and the next first beat.
- With G = 0 and tready held high: one beat per cycle, no bubbles across packets.
- done asserts in the cycle after the final handshake (or after stop in GAP), together with busy falling.
- tvalid, tdata and tlast are registered outputs, with no combinational path from tready.
- Reset asserted mid-packet: outputs clear immediately (async). No resumption; a new start is required.

## Structure
- Package axis_pkt_gen_pkg: state enum (IDLE/SEND/GAP), MODE_INCR/MODE_TAG constants.
- Single module, no sub-modules. Payload mux and counters are inline.

## Test plan
- LEN=4, NUM=2, GAP=0, mode 0, tready=1 → 8 consecutive beats with data 0..7, tlast on beats 3 and 7, done one cycle after beat 7, pkt_cnt=2.
- LEN=3, NUM=2, GAP=5, mode 1, WIDTH=32 → data 0x0000_0000/1/2 with tlast; exactly 5 idle cycles; then 0x0001_0000/1/2 with tlast; done.
- LEN=8, NUM=1, mode 0, tready random 50% → 8 handshakes with data 0..7. Tdata/tlast/tvalid never change while stalled; assertion on the AXIS stability rule.
- NUM=0, LEN=2, GAP=0; stop pulsed mid-beat 0 of packet 5 → packet 5 completes (tlast seen), then IDLE, done, pkt_cnt=6.
- cfg_len=0 start → busy stays 0, no tvalid. Start while busy → no restart, word counter continues.
- rstn low during beat 2 of a packet → all outputs 0 asynchronously. After release, no tvalid until a new start.

Source files
------------

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types for the AXI-Stream packet generator: FSM states and payload modes.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_TAG  = 1'b1;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream traffic generator: fixed-length packets with tlast, counter or tagged payload.
// First beat one cycle after start; all AXIS outputs registered and held while tready is low.
module axis_pkt_gen #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [15:0]          cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic                 cfg_mode,
  output logic [WIDTH-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pkt_cnt
);
  import axis_pkt_gen_pkg::*;

  localparam int HALF = WIDTH / 2;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [15:0]          num_q, num_d;
  logic [GAP_WIDTH-1:0] gap_cfg_q, gap_cfg_d;
  logic                 mode_q, mode_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [15:0]          pkt_q, pkt_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [WIDTH-1:0]     tdata_q, tdata_d;
  logic                 done_q, done_d;
  logic                 hs;
  logic                 last_beat;

  assign hs        = tvalid_q && m_axis_tready;
  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_cfg_d   = gap_cfg_q;
    mode_d      = mode_q;
    beat_d      = beat_q;
    word_d      = word_q;
    pkt_d       = pkt_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && cfg_len != '0) begin
          len_d       = cfg_len;
          num_d       = cfg_num_pkts;
          gap_cfg_d   = cfg_gap;
          mode_d      = cfg_mode;
          beat_d      = '0;
          word_d      = '0;
          pkt_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          word_d = word_q + WIDTH'(1);
          if (last_beat) begin
            pkt_d  = pkt_q + 16'd1;
            beat_d = '0;
            // A stop seen on the last handshake itself also ends the run here.
            if (stop_pend_q || stop || (num_q != '0 && pkt_d == num_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gap_cfg_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_cfg_q;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from next-state values so they can be registered.
    tvalid_d = (state_d == SEND);
    tlast_d  = tvalid_d && (beat_d == len_d - LEN_WIDTH'(1));
    tdata_d  = tdata_q;
    if (tvalid_d) begin
      if (mode_d == MODE_TAG) tdata_d = {HALF'(pkt_d), HALF'(beat_d)};
      else                    tdata_d = word_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      num_q       <= '0;
      gap_cfg_q   <= '0;
      mode_q      <= MODE_INCR;
      beat_q      <= '0;
      word_q      <= '0;
      pkt_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      num_q       <= num_d;
      gap_cfg_q   <= gap_cfg_d;
      mode_q      <= mode_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      pkt_q       <= pkt_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      done_q      <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign pkt_cnt       = pkt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: directed runs, a per-cycle reference model and literal spot checks.
module tb_axis_pkt_gen;
  localparam int WIDTH     = 32;
  localparam int LEN_WIDTH = 16;
  localparam int GAP_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic [LEN_WIDTH-1:0] cfg_len = '0;
  logic [15:0]          cfg_num_pkts = '0;
  logic [GAP_WIDTH-1:0] cfg_gap = '0;
  logic                 cfg_mode = 1'b0;
  logic [WIDTH-1:0]     m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready = 1'b1;
  logic                 busy;
  logic                 done;
  logic [15:0]          pkt_cnt;

  axis_pkt_gen #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .GAP_WIDTH(GAP_WIDTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .stop         (stop),
    .cfg_len      (cfg_len),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_gap      (cfg_gap),
    .cfg_mode     (cfg_mode),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .done         (done),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  assert property (@(posedge clk) disable iff (!rstn)
    (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

  int checks = 0;
  int errors = 0;

  // Reference model state: expected beat k of a run is packet k/len, beat k%len.
  int  m_len, m_mode, m_gap, m_total;
  bit  m_active;
  int  hs_idx, idle_cnt, cyc;
  bit  after_last, prev_stall, prev_final;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  logic [WIDTH-1:0] log_dat[$];
  bit               log_last[$];
  int               log_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_data(input int idx);
    int pkt;
    int beat;
    pkt  = idx / m_len;
    beat = idx % m_len;
    if (m_mode == 1) return {pkt[15:0], beat[15:0]};
    return WIDTH'(idx);
  endfunction

  task automatic start_run(input int len, input int num, input int gap, input int mode);
    cfg_len      = LEN_WIDTH'(len);
    cfg_num_pkts = 16'(num);
    cfg_gap      = GAP_WIDTH'(gap);
    cfg_mode     = mode[0];
    start        = 1'b1;
    m_len = len; m_mode = mode; m_gap = gap; m_total = len * num;
    m_active = 1'b1; hs_idx = 0; idle_cnt = 0; after_last = 1'b0; prev_final = 1'b0;
    log_dat.delete(); log_last.delete(); log_cyc.delete();
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_latency_tvalid", m_axis_tvalid, 1);
    chk("start_latency_busy", busy, 1);
  endtask

  task automatic wait_done(input string name, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk(name, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_data(input string name, input logic [WIDTH-1:0] d);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == d) begin found = 1'b1; break; end
    end
    chk(name, found, 1);
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          cyc++;
          if (!rstn) begin
            m_active = 1'b0; prev_stall = 1'b0; prev_final = 1'b0; after_last = 1'b0;
          end else begin
            chk("done_timing", done, prev_final);
            prev_final = 1'b0;
            if (done) begin
              chk("busy_at_done", busy, 0);
              chk("pkt_cnt_at_done", pkt_cnt, (m_len != 0) ? hs_idx / m_len : 0);
              m_active = 1'b0;
            end
            if (prev_stall) begin
              chk("stall_tvalid", m_axis_tvalid, 1);
              chk("stall_tdata", m_axis_tdata, prev_data);
              chk("stall_tlast", m_axis_tlast, prev_last);
            end
            if (!m_active) begin
              chk("idle_tvalid", m_axis_tvalid, 0);
            end else if (m_axis_tvalid) begin
              if (after_last) begin
                chk("gap_len", idle_cnt, m_gap);
                after_last = 1'b0;
              end
              if (m_axis_tready) begin
                chk("beat_data", m_axis_tdata, exp_data(hs_idx));
                chk("beat_last", m_axis_tlast, (hs_idx % m_len) == m_len - 1);
                log_dat.push_back(m_axis_tdata);
                log_last.push_back(m_axis_tlast);
                log_cyc.push_back(cyc);
                hs_idx++;
                if (hs_idx % m_len == 0) begin after_last = 1'b1; idle_cnt = 0; end
                prev_final = (m_total != 0) && (hs_idx == m_total);
              end
            end else if (after_last) begin
              idle_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
          end
        end
      end
    join_none

    // Reset state
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back incrementing packets
    start_run(4, 2, 0, 0);
    wait_done("t1_done", 100);
    chk("t1_beats", log_dat.size(), 8);
    chk("t1_dat0", log_dat[0], 32'h0);
    chk("t1_dat7", log_dat[7], 32'h7);
    chk("t1_last2", log_last[2], 0);
    chk("t1_last3", log_last[3], 1);
    chk("t1_last7", log_last[7], 1);
    chk("t1_no_bubbles", log_cyc[7] - log_cyc[0], 7);
    chk("t1_pkt_cnt", pkt_cnt, 2);

    // Tagged payload with a five-cycle gap
    start_run(3, 2, 5, 1);
    wait_done("t2_done", 100);
    chk("t2_beats", log_dat.size(), 6);
    chk("t2_dat0", log_dat[0], 32'h0000_0000);
    chk("t2_dat2", log_dat[2], 32'h0000_0002);
    chk("t2_dat3", log_dat[3], 32'h0001_0000);
    chk("t2_dat5", log_dat[5], 32'h0001_0002);
    chk("t2_last2", log_last[2], 1);
    chk("t2_last5", log_last[5], 1);
    chk("t2_gap_cycles", log_cyc[3] - log_cyc[2] - 1, 5);
    chk("t2_pkt_cnt", pkt_cnt, 2);

    // Random backpressure
    m_axis_tready = 1'b0;
    start_run(8, 1, 0, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        m_axis_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) begin seen = 1'b1; break; end
      end
      chk("t3_done", seen, 1);
    end
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    chk("t3_beats", log_dat.size(), 8);
    chk("t3_dat7", log_dat[7], 32'h7);
    chk("t3_last7", log_last[7], 1);

    // Continuous run stopped during beat 0 of packet 5
    start_run(2, 0, 0, 0);
    wait_data("t4_reach_pkt5", 32'd10);
    m_total = 12;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done("t4_done", 50);
    chk("t4_beats", log_dat.size(), 12);
    chk("t4_last11", log_last[11], 1);
    chk("t4_pkt_cnt", pkt_cnt, 6);

    // Zero-length start is ignored; pkt_cnt holds
    cfg_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_tvalid", m_axis_tvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_later", busy, 0);
    chk("t5_pkt_cnt_hold", pkt_cnt, 6);

    // Start while busy does not restart the run
    start_run(4, 2, 0, 0);
    wait_data("t6_reach_beat2", 32'd2);
    cfg_len  = LEN_WIDTH'(3);
    cfg_mode = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_busy", busy, 1);
    wait_done("t6_done", 100);
    chk("t6_beats", log_dat.size(), 8);
    chk("t6_dat5", log_dat[5], 32'h5);
    chk("t6_pkt_cnt", pkt_cnt, 2);

    // Asynchronous reset in the middle of a packet
    start_run(4, 1, 0, 0);
    wait_data("t7_reach_beat2", 32'd2);
    #2 rstn = 1'b0;
    #1;
    chk("t7_rst_tvalid", m_axis_tvalid, 0);
    chk("t7_rst_tlast", m_axis_tlast, 0);
    chk("t7_rst_tdata", m_axis_tdata, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_done", done, 0);
    chk("t7_rst_pkt_cnt", pkt_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t7_no_resume_busy", busy, 0);
    chk("t7_no_resume_tvalid", m_axis_tvalid, 0);
    start_run(2, 1, 0, 1);
    wait_done("t7_restart_done", 50);
    chk("t7_beats", log_dat.size(), 2);
    chk("t7_dat1", log_dat[1], 32'h0000_0001);
    chk("t7_pkt_cnt", pkt_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
